ghist_ctrl: RTL

Access controller for the 40-entry x 72-bit global-history RAM macro in the frontend branch-predictor path. It clears the RAM after reset and on flush request, arbitrating two write requesters (misprediction repair, commit update). It also serves one read requester, adding write-to-read forwarding and out-of-range address protection. It owns both macro ports; no other block drives the RAM.

---
 rtl/ghist_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ghist_ctrl.sv
// Access controller for the 40x72 global-history RAM: post-reset/flush clear sweep,
// repair/update write arbitration with starvation guard, and a 1-cycle read path with forwarding.
module ghist_ctrl #(
    parameter int DEPTH      = 40,
    parameter int AW         = 6,
    parameter int DW         = 72,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush_req,
    output logic          init_done,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_resp_valid,
    output logic [DW-1:0] rd_resp_data,
    input  logic          rep_valid,
    output logic          rep_ready,
    input  logic [AW-1:0] rep_addr,
    input  logic [DW-1:0] rep_data,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [AW-1:0] upd_addr,
    input  logic [DW-1:0] upd_data,
    output logic          addr_err,
    output logic          mem_R0_en,
    output logic [AW-1:0] mem_R0_addr,
    input  logic [DW-1:0] mem_R0_data,
    output logic          mem_W0_en,
    output logic [AW-1:0] mem_W0_addr,
    output logic [DW-1:0] mem_W0_data
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
    localparam logic [SW-1:0] STARVE_A = SW'(STARVE_MAX);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rsp_valid_q, rsp_oor_q, rsp_bypass_q, addr_err_q;
    logic [DW-1:0] rsp_data_q;

    logic accept_en, rd_acc, rd_oor, rep_oor, upd_oor;
    logic rep_gnt, upd_gnt, wr_gnt, upd_force, bypass, err_d;

    // Requests are only accepted in RUN, never in the flush cycle, never while reset is held.
    assign accept_en = (state_q == RUN) && !flush_req && reset_n;
    assign rd_oor    = rd_addr  >= DEPTH_A;
    assign rep_oor   = rep_addr >= DEPTH_A;
    assign upd_oor   = upd_addr >= DEPTH_A;

    // Out-of-range writes are accepted and dropped without taking the write port.
    assign upd_force = upd_valid && !upd_oor && (starve_q >= STARVE_A);
    assign rep_gnt   = accept_en && rep_valid && !rep_oor && !upd_force;
    assign upd_gnt   = accept_en && upd_valid && !upd_oor && !rep_gnt;
    assign wr_gnt    = rep_gnt || upd_gnt;

    assign rep_ready = rep_gnt || (accept_en && rep_valid && rep_oor);
    assign upd_ready = upd_gnt || (accept_en && upd_valid && upd_oor);
    assign rd_ready  = accept_en;
    assign rd_acc    = accept_en && rd_valid;

    assign init_done   = (state_q == RUN);
    assign mem_R0_en   = rd_acc && !rd_oor;
    assign mem_R0_addr = rd_addr;

    always_comb begin
        mem_W0_en   = 1'b0;
        mem_W0_addr = upd_addr;
        mem_W0_data = upd_data;
        if (state_q == CLEAR) begin
            mem_W0_en   = reset_n;
            mem_W0_addr = cnt_q;
            mem_W0_data = '0;
        end else if (rep_gnt) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = rep_addr;
            mem_W0_data = rep_data;
        end else if (upd_gnt) begin
            mem_W0_en = 1'b1;
        end
    end

    assign bypass = rd_acc && !rd_oor && wr_gnt && (mem_W0_addr == rd_addr);
    assign err_d  = (rd_acc && rd_oor) || (accept_en && rep_valid && rep_oor)
                  || (accept_en && upd_valid && upd_oor);

    // NOTE: every variable gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ROW) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (flush_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
        if (!upd_valid || upd_gnt)
            starve_d = '0;
        else if (rep_gnt && starve_q != STARVE_A)
            starve_d = starve_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            starve_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_oor_q    <= 1'b0;
            rsp_bypass_q <= 1'b0;
            rsp_data_q   <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            rsp_valid_q  <= rd_acc;
            rsp_oor_q    <= rd_oor;
            rsp_bypass_q <= bypass;
            rsp_data_q   <= mem_W0_data;
            addr_err_q   <= err_d;
        end
    end

    assign rd_resp_valid = rsp_valid_q;
    assign addr_err      = addr_err_q;

    always_comb begin
        rd_resp_data = '0;
        if (rsp_valid_q && !rsp_oor_q)
            rd_resp_data = rsp_bypass_q ? rsp_data_q : mem_R0_data;
    end

endmodule
